// File: rtl/hex_pkg.sv
// Shared definitions for the scrolling 7-segment message display:
// glyph codes, selection and FSM enums, selection decode and message contents.
package hex_pkg;

    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_N     = 7'b0101011;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_T     = 7'b0000111;
    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_H     = 7'b0001011;
    localparam logic [6:0] GLYPH_I     = 7'b1101111;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        SEL_RAND = 2'd0,
        SEL_BEE  = 2'd1,
        SEL_TOAD = 2'd2,
        SEL_SHIP = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCROLL = 2'd1,
        ST_PAUSE  = 2'd2
    } state_e;

    function automatic sel_e decode_sel(input logic rnd, input logic [1:0] pat);
        sel_e s;
        if (rnd) begin
            s = SEL_RAND;
        end else begin
            case (pat)
                2'b01:   s = SEL_BEE;
                2'b10:   s = SEL_TOAD;
                default: s = SEL_SHIP;
            endcase
        end
        return s;
    endfunction

    // Glyph at position idx of the message buffer; text is left-justified, rest blank.
    function automatic logic [6:0] msg_char(input sel_e sel, input int idx);
        logic [6:0] g;
        g = GLYPH_BLANK;
        case (sel)
            SEL_RAND: begin
                case (idx)
                    0:       g = GLYPH_R;
                    1:       g = GLYPH_A;
                    2:       g = GLYPH_N;
                    3:       g = GLYPH_D;
                    default: g = GLYPH_BLANK;
                endcase
            end
            SEL_BEE: begin
                case (idx)
                    0:       g = GLYPH_B;
                    1:       g = GLYPH_E;
                    2:       g = GLYPH_E;
                    default: g = GLYPH_BLANK;
                endcase
            end
            SEL_TOAD: begin
                case (idx)
                    0:       g = GLYPH_T;
                    1:       g = GLYPH_O;
                    2:       g = GLYPH_A;
                    3:       g = GLYPH_D;
                    default: g = GLYPH_BLANK;
                endcase
            end
            SEL_SHIP: begin
                case (idx)
                    0:       g = GLYPH_S;
                    1:       g = GLYPH_H;
                    2:       g = GLYPH_I;
                    3:       g = GLYPH_P;
                    default: g = GLYPH_BLANK;
                endcase
            end
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_tick.sv
// Free-running scroll-step divider: tick is high for the one cycle the count sits at DIV-1.
module hex_tick #(
    parameter int DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Divider count, wrapping at DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/hex_scroller.sv
// Scrolls one of four fixed messages across NUM_DIGITS active-low 7-segment digits,
// pausing at offset 0 after each wrap and restarting whenever the selection changes.
import hex_pkg::*;

module hex_scroller #(
    parameter int NUM_DIGITS  = 6,
    parameter int MSG_LEN     = 12,
    parameter int TICK_DIV    = 12_500_000,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       random,
    input  logic [1:0]                 pattern,
    input  logic                       scroll_en,
    output logic [NUM_DIGITS-1:0][6:0] leds
);

    localparam int            OW       = $clog2(MSG_LEN);
    localparam logic [OW-1:0] OFF_LAST = OW'(MSG_LEN - 1);
    localparam int            PW       = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);

    sel_e                       w_sel;
    sel_e                       r_sel;
    logic                       w_sel_chg;
    state_e                     r_state;
    state_e                     w_state_nx;
    logic [OW-1:0]              r_off;
    logic [OW-1:0]              w_off_nx;
    logic [PW-1:0]              r_pcnt;
    logic [PW-1:0]              w_pcnt_nx;
    logic                       w_tick;
    logic                       w_tick_rst;
    logic [NUM_DIGITS-1:0][6:0] r_leds;
    logic [NUM_DIGITS-1:0][6:0] w_leds_nx;

    // Buffer index shown on digit i: (off + NUM_DIGITS-1-i) mod MSG_LEN without a divider
    function automatic logic [OW-1:0] buf_pos(input logic [OW-1:0] off, input int i);
        logic [OW:0] s;
        s = {1'b0, off} + (OW+1)'(NUM_DIGITS - 1 - i);
        if (s >= (OW+1)'(MSG_LEN)) begin
            s = s - (OW+1)'(MSG_LEN);
        end else begin
            s = s;
        end
        return s[OW-1:0];
    endfunction

    assign w_sel      = decode_sel(random, pattern);
    assign w_sel_chg  = (w_sel != r_sel);
    // Holding the divider clear while static makes the first step land a full period after enable.
    assign w_tick_rst = reset | w_sel_chg | (r_state == ST_STATIC);

    hex_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (w_tick_rst),
        .tick  (w_tick)
    );

    // Next state, offset and pause count; a selection change outranks any tick
    always_comb begin
        w_state_nx = r_state;
        w_off_nx   = r_off;
        w_pcnt_nx  = r_pcnt;
        if (w_sel_chg) begin
            w_off_nx   = {OW{1'b0}};
            w_pcnt_nx  = {PW{1'b0}};
            w_state_nx = scroll_en ? ST_PAUSE : ST_STATIC;
        end else begin
            case (r_state)
                ST_STATIC: begin
                    w_off_nx  = {OW{1'b0}};
                    w_pcnt_nx = {PW{1'b0}};
                    if (scroll_en) begin
                        w_state_nx = ST_SCROLL;
                    end else begin
                        w_state_nx = ST_STATIC;
                    end
                end
                ST_SCROLL: begin
                    if (!scroll_en) begin
                        w_state_nx = ST_STATIC;
                        w_off_nx   = {OW{1'b0}};
                        w_pcnt_nx  = {PW{1'b0}};
                    end else if (w_tick) begin
                        if (r_off == OFF_LAST) begin
                            w_off_nx   = {OW{1'b0}};
                            w_pcnt_nx  = {PW{1'b0}};
                            w_state_nx = (PAUSE_TICKS == 0) ? ST_SCROLL : ST_PAUSE;
                        end else begin
                            w_off_nx = r_off + OW'(1);
                        end
                    end else begin
                        w_off_nx = r_off;
                    end
                end
                ST_PAUSE: begin
                    if (!scroll_en) begin
                        w_state_nx = ST_STATIC;
                        w_off_nx   = {OW{1'b0}};
                        w_pcnt_nx  = {PW{1'b0}};
                    end else if (w_tick) begin
                        if (r_pcnt == P_LAST) begin
                            w_pcnt_nx  = {PW{1'b0}};
                            w_state_nx = ST_SCROLL;
                        end else begin
                            w_pcnt_nx = r_pcnt + PW'(1);
                        end
                    end else begin
                        w_pcnt_nx = r_pcnt;
                    end
                end
                default: begin
                    w_state_nx = ST_STATIC;
                    w_off_nx   = {OW{1'b0}};
                    w_pcnt_nx  = {PW{1'b0}};
                end
            endcase
        end
    end

    // Digit contents for the current selection and offset
    always_comb begin
        w_leds_nx = {NUM_DIGITS{GLYPH_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_leds_nx[i] = msg_char(r_sel, int'(buf_pos(r_off, i)));
        end
    end

    // State registers and registered segment drive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= w_sel;
            r_state <= ST_STATIC;
            r_off   <= {OW{1'b0}};
            r_pcnt  <= {PW{1'b0}};
            r_leds  <= {NUM_DIGITS{GLYPH_BLANK}};
        end else begin
            r_sel   <= w_sel;
            r_state <= w_state_nx;
            r_off   <= w_off_nx;
            r_pcnt  <= w_pcnt_nx;
            r_leds  <= w_leds_nx;
        end
    end

    assign leds = r_leds;

endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment digits driven.
REQ-002 SHALL have parameter MSG_LEN, default 12: characters per message buffer; legal range is MSG_LEN >= NUM_DIGITS and MSG_LEN >= 4.
REQ-003 SHALL have parameter TICK_DIV, default 12_500_000: clk cycles per scroll step.
REQ-004 SHALL have parameter PAUSE_TICKS, default 4: scroll steps held at offset 0 after each wrap.
REQ-005 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- random  in  1  selects the RAND message; overrides pattern.
- pattern  in  2  message select: 01 = BEE, 10 = TOAD, 00 or 11 = SHIP.
- scroll_en  in  1  1 = scroll the message, 0 = show it static.
- leds  out  NUM_DIGITS x 7  active-low segments, bit 6..0 = segments 6..0; leds[NUM_DIGITS-1] is the leftmost digit.

Function
REQ-006 SHALL map glyphs (segments 6543210) as follows:
- r = 0101111, A = 0001000, n = 0101011, D = 0100001
- b = 0000011, E = 0000110, t = 0000111, O = 1000000
- S = 0010010, H = 0001011, I = 1101111, P = 0001100
- blank = 1111111
REQ-007 SHALL build each message as a MSG_LEN buffer: text left-justified at index 0 (RAND = r,A,n,D; BEE = b,E,E; TOAD = t,O,A,D; SHIP = S,H,I,P), remaining indices blank.
REQ-008 SHALL register the decoded selection each cycle and flag a selection change when the registered value differs from the new decode.
REQ-009 SHALL keep a tick counter running 0..TICK_DIV-1 and pulse tick for one cycle when the count equals TICK_DIV-1, then wrap to 0.
REQ-010 SHALL keep an offset register in the range 0..MSG_LEN-1.
REQ-011 SHALL drive digit i from buffer[(offset + NUM_DIGITS-1-i) mod MSG_LEN], registered, so leds follow offset and selection with one cycle of latency.
REQ-012 SHALL implement FSM STATIC, SCROLL, PAUSE:
- STATIC: offset held at 0; go to SCROLL when scroll_en = 1.
- SCROLL: on tick, offset increments; when offset = MSG_LEN-1 and tick, offset goes to 0 and state goes to PAUSE.
- PAUSE: count PAUSE_TICKS ticks at offset 0, then go to SCROLL.
REQ-013 SHALL, when scroll_en = 0 in SCROLL or PAUSE, go to STATIC with offset 0 and the pause count cleared on the next cycle.
REQ-014 SHALL, on a selection change, clear offset, the tick counter and the pause count, and enter PAUSE if scroll_en = 1, else STATIC.
REQ-015 SHALL give a selection change priority over a tick in the same cycle; the tick is discarded.
REQ-016 SHALL, when PAUSE_TICKS = 0, go from wrap directly back to SCROLL with no hold.
REQ-017 SHALL treat changes to random or pattern as glitch-tolerant: any single-cycle change restarts the display per REQ-014.

Reset
REQ-018 SHALL, while reset = 1, set leds to all blank (7'b1111111 on every digit), offset 0, tick counter 0, pause count 0, state STATIC, and the registered selection to the current decode; reset overrides every other event.
REQ-019 SHALL show the selected message at offset 0 on leds on the first cycle after reset is released.

Structure
REQ-020 SHALL place the glyph constants, the selection enum (SEL_RAND, SEL_BEE, SEL_TOAD, SEL_SHIP), the FSM state enum, and the message-buffer construction function in a shared package hex_pkg.
REQ-021 SHALL implement the tick counter as sub-module hex_tick, parameter DIV, with ports clk, reset and a tick output.

Verification (bench parameters: NUM_DIGITS = 6, MSG_LEN = 8, TICK_DIV = 4, PAUSE_TICKS = 2)
REQ-022 SHALL cover reset release with random = 0, pattern = 01, scroll_en = 0 -> leds = b,E,E,blank,blank,blank one cycle after release, held indefinitely.
REQ-023 SHALL cover scroll_en = 1 with BEE -> every 4 cycles leds shift left one glyph: E,E,blank... then E,blank...; after the 8th step leds = b,E,E,blank... held for 8 cycles (PAUSE), then scrolling resumes.
REQ-024 SHALL cover raising random = 1 mid-scroll at offset 3 -> next cycle offset = 0, state = PAUSE, leds = r,A,n,D,blank,blank one cycle later.
REQ-025 SHALL cover a pattern change from 01 to 10 in the same cycle as a tick -> offset = 0, not 1; leds = t,O,A,D,blank,blank.
REQ-026 SHALL cover dropping scroll_en to 0 in PAUSE -> STATIC at offset 0; raising it again -> first shift exactly 4 cycles later.
REQ-027 SHALL cover asserting reset mid-scroll -> leds all 1111111 during reset; SHIP (pattern = 00) at offset 0 one cycle after release.
